// File: rtl/tartaruga_pkg.sv
// rtl/tartaruga_pkg.sv - shared types and constants for the tartaruga memory stage
package tartaruga_pkg;

    localparam int DMEM_POS_DEFAULT = 1024;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    typedef enum logic [2:0] {
        BYTE,
        HALF,
        WORD,
        BYTE_U,
        HALF_U
    } mem_size_t;

    typedef enum logic [1:0] {
        ALU,
        MEM,
        PC_4
    } wb_origin_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] bits;
        logic [2:0]  func3;
    } instr_t;

    typedef struct packed {
        logic        valid;
        instr_t      instr;
        logic [31:0] result;
        logic [31:0] data_rs2;
        logic        branch_taken;
        logic        store_to_mem;
        wb_origin_t  wb_origin;
    } exe_to_mem_t;

    typedef struct packed {
        logic        valid;
        instr_t      instr;
        logic [31:0] result;
        logic        branch_taken;
        logic [31:0] branched_pc;
    } mem_to_wb_t;

    // Unlisted func3 codes fall back to a full-word access.
    function automatic mem_size_t decode_size(input logic [2:0] func3);
        case (func3)
            F3_BYTE:   return BYTE;
            F3_HALF:   return HALF;
            F3_BYTE_U: return BYTE_U;
            F3_HALF_U: return HALF_U;
            default:   return WORD;
        endcase
    endfunction

endpackage

// File: rtl/tartaruga_dmem.sv
// rtl/tartaruga_dmem.sv - byte-lane data memory, per-byte write enable, combinational read
module tartaruga_dmem #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: load/store with size decode, alignment check,
// lane steering and extension, registered towards writeback.
module mem_stage
    import tartaruga_pkg::*;
#(
    parameter int DMEM_POS = DMEM_POS_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  exe_to_mem_t exe_to_mem_i,
    output mem_to_wb_t  mem_to_wb_o,
    output logic        misaligned_o
);

    localparam int AW = $clog2(DMEM_POS);

    mem_size_t   size;
    logic        is_mem;
    logic        misaligned;
    logic        accept;
    logic [1:0]  ofs;
    logic [AW-1:0] word_idx;
    logic [3:0]  lane_mask;
    logic [3:0]  lane_we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    mem_to_wb_t  next_out;

    assign ofs      = exe_to_mem_i.result[1:0];
    assign word_idx = exe_to_mem_i.result[AW+1:2];
    assign accept   = exe_to_mem_i.valid && !stall_i && !flush_i && !rst_i;

    always_comb begin
        size       = decode_size(exe_to_mem_i.instr.func3);
        is_mem     = exe_to_mem_i.store_to_mem || (exe_to_mem_i.wb_origin == MEM);
        misaligned = 1'b0;
        if (is_mem) begin
            case (size)
                HALF, HALF_U: misaligned = ofs[0];
                WORD:         misaligned = (ofs != 2'b00);
                default:      misaligned = 1'b0;
            endcase
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        lane_mask = 4'b1111;
        wdata     = exe_to_mem_i.data_rs2;
        case (size)
            BYTE, BYTE_U: begin
                lane_mask = 4'b0001 << ofs;
                wdata     = {4{exe_to_mem_i.data_rs2[7:0]}};
            end
            HALF, HALF_U: begin
                lane_mask = ofs[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{exe_to_mem_i.data_rs2[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                wdata     = exe_to_mem_i.data_rs2;
            end
        endcase
        lane_we = (accept && exe_to_mem_i.store_to_mem && !misaligned) ? lane_mask : 4'b0000;
    end

    tartaruga_dmem #(
        .DEPTH(DMEM_POS)
    ) u_dmem (
        .clk   (clk_i),
        .we    (lane_we),
        .addr  (word_idx),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_comb begin
        sel_byte = rdata[{ofs, 3'b000} +: 8];
        sel_half = ofs[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            BYTE:    load_data = {{24{sel_byte[7]}}, sel_byte};
            BYTE_U:  load_data = {24'h0, sel_byte};
            HALF:    load_data = {{16{sel_half[15]}}, sel_half};
            HALF_U:  load_data = {16'h0, sel_half};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        next_out              = '0;
        next_out.valid        = 1'b1;
        next_out.instr        = exe_to_mem_i.instr;
        next_out.branch_taken = exe_to_mem_i.branch_taken;
        next_out.branched_pc  = exe_to_mem_i.branch_taken ? exe_to_mem_i.result : 32'h0;
        case (exe_to_mem_i.wb_origin)
            MEM:     next_out.result = load_data;
            PC_4:    next_out.result = exe_to_mem_i.instr.pc + 32'd4;
            default: next_out.result = exe_to_mem_i.result;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_to_wb_o  <= '0;
            misaligned_o <= 1'b0;
        end else if (flush_i) begin
            mem_to_wb_o  <= '0;
            misaligned_o <= 1'b0;
        end else if (stall_i) begin
            mem_to_wb_o  <= mem_to_wb_o;
            misaligned_o <= misaligned_o;
        end else if (!exe_to_mem_i.valid) begin
            mem_to_wb_o  <= '0;
            misaligned_o <= 1'b0;
        end else if (misaligned) begin
            mem_to_wb_o  <= '0;
            misaligned_o <= 1'b1;
        end else begin
            mem_to_wb_o  <= next_out;
            misaligned_o <= 1'b0;
        end
    end

endmodule
